serial_addsub_fsm: RTL and testbench
====================================

Name: serial_addsub_fsm

Overview:
- Parametrised bit-serial add/subtract engine built around a small FSM.
- Latches two WIDTH-bit operands and a mode on a start pulse, then processes one bit per clock, LSB first, through a single full-adder slice.
- Returns a registered result with carry/borrow, overflow and zero flags.
- Generalises the fixed 8-bit serial subtractor to any width, adds an add mode, a start/busy/done handshake and status flags.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CW, $clog2(WIDTH+1), bit-counter width; derived, must not be overridden.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- mode  input  1  0 = a+b, 1 = a-b; latched with start
- a  input  WIDTH  operand A; latched with start
- b  input  WIDTH  operand B; latched with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: result and flags valid
- result  output  WIDTH  sum/difference; holds until the next completion or reset
- cout  output  1  add: carry out; sub: borrow (1 when a < b unsigned)
- overflow  output  1  two's-complement signed overflow
- zero  output  1  result == 0

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; result=0; cout=0; overflow=0; zero=0; counter and shift registers cleared. An operation in progress is aborted with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches a, b^{WIDTH{mode}}, and mode; sets carry=mode, cnt=0; goes to RUN. start=0 stays in IDLE.
- RUN, each edge:
  - s = a_sr[0]^b_sr[0]^carry; carry updates to the majority of those three bits.
  - s is shifted into the MSB of the internal sum shift register; a_sr and b_sr shift right; cnt++.
  - The edge with cnt==WIDTH-1 processes the final bit: result, cout and flags are written at that edge, and the state goes to DONE.
- Latency: start sampled at edge E0 -> done high in the cycle after edge E0+WIDTH (WIDTH=8: 8 cycles). busy is high for exactly WIDTH cycles.
- DONE: done=1 for one cycle. start=1 begins a new operation exactly as from IDLE (back-to-back, no idle gap); otherwise go to IDLE.
- start while in RUN: ignored. The operation is unaffected and no request is queued.
- a, b and mode are don't-care outside the start-sampling edge.
- Flags:
  - cout = carry_final ^ mode.
  - overflow = carry into MSB ^ carry out of MSB (carry before and after the last bit).
  - zero = (final result == 0).
- result, cout, overflow and zero change only at a completing edge or at reset.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

Test Plan (WIDTH=8 unless stated):
- Reset, then start with mode=1, a=23, b=2 -> busy for 8 cycles; done pulse 8 cycles after start; result=21; cout=0; overflow=0; zero=0.
- mode=1, a=8, b=23 -> result=0xF1 (241); cout=1 (borrow); overflow=0. Then mode=0, a=100, b=50 -> result=150; cout=0; overflow=1.
- mode=0, a=200, b=123 -> result=67; cout=1; overflow=0. mode=1, a=74, b=74 -> result=0; zero=1; cout=0.
- Assert start again at cycle 3 of RUN with different operands -> ignored; original result delivered on schedule. Assert start in the done cycle with a=110, b=42, mode=1 -> second done exactly 8 cycles later, result=68.
- Assert reset mid-RUN (cycle 4) -> all outputs 0 immediately (asynchronously); no done pulse; a fresh start afterwards completes normally.
- WIDTH=16: mode=1, a=0x0000, b=0x0001 -> 16-cycle latency; result=0xFFFF; cout=1; overflow=0. WIDTH=2: mode=0, a=1, b=1 -> result=2; overflow=1.

Source files
------------

// File: rtl/serial_addsub_fsm.sv
// Bit-serial add/subtract engine: one full-adder slice, LSB first, one bit per clock.
// Subtraction is a + ~b + 1, so the adder carry is seeded with the mode bit.
module serial_addsub_fsm #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;

    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_sr_r;
    logic             carry_r;
    logic             mode_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             overflow_r;
    logic             zero_r;

    logic [WIDTH-1:0] a_sr_nxt_s;
    logic [WIDTH-1:0] b_sr_nxt_s;
    logic [WIDTH-1:0] sum_sr_nxt_s;
    logic             carry_nxt_s;
    logic             mode_nxt_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic [WIDTH-1:0] result_nxt_s;
    logic             cout_nxt_s;
    logic             overflow_nxt_s;
    logic             zero_nxt_s;

    logic             sum_bit_s;
    logic             carry_out_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] final_sum_s;

    // Full-adder slice on the current LSBs and the shifted-in sum word.
    always_comb begin
        sum_bit_s   = a_sr_r[0] ^ b_sr_r[0] ^ carry_r;
        carry_out_s = maj3(a_sr_r[0], b_sr_r[0], carry_r);
        last_bit_s  = (cnt_r == CW'(WIDTH - 1));
        final_sum_s = {sum_bit_s, sum_sr_r[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a request is only taken when not in RUN.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                accept_s    = 1'b0;
            end
        endcase
    end

    // Datapath next values: load on accept, shift one bit per RUN cycle.
    always_comb begin
        a_sr_nxt_s     = a_sr_r;
        b_sr_nxt_s     = b_sr_r;
        sum_sr_nxt_s   = sum_sr_r;
        carry_nxt_s    = carry_r;
        mode_nxt_s     = mode_r;
        cnt_nxt_s      = cnt_r;
        result_nxt_s   = result_r;
        cout_nxt_s     = cout_r;
        overflow_nxt_s = overflow_r;
        zero_nxt_s     = zero_r;
        if (accept_s) begin
            a_sr_nxt_s   = a;
            b_sr_nxt_s   = b ^ {WIDTH{mode}};
            sum_sr_nxt_s = {WIDTH{1'b0}};
            carry_nxt_s  = mode;
            mode_nxt_s   = mode;
            cnt_nxt_s    = {CW{1'b0}};
        end else if (state_r == RUN) begin
            a_sr_nxt_s   = {1'b0, a_sr_r[WIDTH-1:1]};
            b_sr_nxt_s   = {1'b0, b_sr_r[WIDTH-1:1]};
            sum_sr_nxt_s = final_sum_s;
            carry_nxt_s  = carry_out_s;
            cnt_nxt_s    = cnt_r + CW'(1);
            // carry_r is the carry into the MSB on the final bit.
            if (last_bit_s) begin
                result_nxt_s   = final_sum_s;
                cout_nxt_s     = carry_out_s ^ mode_r;
                overflow_nxt_s = carry_r ^ carry_out_s;
                zero_nxt_s     = (final_sum_s == {WIDTH{1'b0}});
            end else begin
                result_nxt_s   = result_r;
                cout_nxt_s     = cout_r;
                overflow_nxt_s = overflow_r;
                zero_nxt_s     = zero_r;
            end
        end else begin
            a_sr_nxt_s   = a_sr_r;
            b_sr_nxt_s   = b_sr_r;
            sum_sr_nxt_s = sum_sr_r;
            cnt_nxt_s    = cnt_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_sr_r     <= {WIDTH{1'b0}};
            b_sr_r     <= {WIDTH{1'b0}};
            sum_sr_r   <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            mode_r     <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
        end else begin
            a_sr_r     <= a_sr_nxt_s;
            b_sr_r     <= b_sr_nxt_s;
            sum_sr_r   <= sum_sr_nxt_s;
            carry_r    <= carry_nxt_s;
            mode_r     <= mode_nxt_s;
            cnt_r      <= cnt_nxt_s;
            busy_r     <= (state_nxt_s == RUN);
            done_r     <= (state_nxt_s == DONE);
            result_r   <= result_nxt_s;
            cout_r     <= cout_nxt_s;
            overflow_r <= overflow_nxt_s;
            zero_r     <= zero_nxt_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign cout     = cout_r;
    assign overflow = overflow_r;
    assign zero     = zero_r;

endmodule

// File: tb/tb_serial_addsub_fsm.sv
// Bench for serial_addsub_fsm: WIDTH=8 against an arithmetic reference model,
// plus directed WIDTH=16 and WIDTH=2 instances.
module tb_serial_addsub_fsm;

    localparam int W8 = 8;

    logic        clock = 1'b0;
    logic        reset;

    logic        start8, mode8, busy8, done8, cout8, ovf8, zero8;
    logic [7:0]  a8, b8, result8;
    logic        start16, mode16, busy16, done16, cout16, ovf16, zero16;
    logic [15:0] a16, b16, result16;
    logic        start2, mode2, busy2, done2, cout2, ovf2, zero2;
    logic [1:0]  a2, b2, result2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    serial_addsub_fsm #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .cout(cout8),
        .overflow(ovf8), .zero(zero8)
    );

    serial_addsub_fsm #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .mode(mode16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .cout(cout16),
        .overflow(ovf16), .zero(zero16)
    );

    serial_addsub_fsm #(.WIDTH(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .mode(mode2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(result2), .cout(cout2),
        .overflow(ovf2), .zero(zero2)
    );

    typedef struct packed {
        logic [7:0] res;
        logic       co;
        logic       ov;
        logic       z;
    } calc_t;

    // Plain integer arithmetic: unsigned view for result/carry, signed view for overflow.
    function automatic calc_t model_calc(input logic m, input logic [7:0] x, input logic [7:0] y);
        calc_t r;
        int ux, uy, sx, sy, u, s;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (m) begin
            u    = ux - uy;
            s    = sx - sy;
            r.co = (ux < uy);
        end else begin
            u    = ux + uy;
            s    = sx + sy;
            r.co = (u > 255);
        end
        r.res = u[7:0];
        r.ov  = (s > 127) || (s < -128);
        r.z   = (r.res == 8'd0);
        return r;
    endfunction

    int         run_left;
    calc_t      pend;
    logic       m_done;
    logic [7:0] m_res;
    logic       m_co, m_ov, m_z;

    // Reference: a request is taken whenever no operation is running; results land WIDTH edges later.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            run_left <= 0;
            pend     <= '0;
            m_done   <= 1'b0;
            m_res    <= 8'd0;
            m_co     <= 1'b0;
            m_ov     <= 1'b0;
            m_z      <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (run_left == 0) begin
                if (start8) begin
                    run_left <= W8;
                    pend     <= model_calc(mode8, a8, b8);
                end
            end else begin
                run_left <= run_left - 1;
                if (run_left == 1) begin
                    m_done <= 1'b1;
                    m_res  <= pend.res;
                    m_co   <= pend.co;
                    m_ov   <= pend.ov;
                    m_z    <= pend.z;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("busy",     64'(busy8),   64'(run_left != 0));
        check("done",     64'(done8),   64'(m_done));
        check("result",   64'(result8), 64'(m_res));
        check("cout",     64'(cout8),   64'(m_co));
        check("overflow", 64'(ovf8),    64'(m_ov));
        check("zero",     64'(zero8),   64'(m_z));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0:       return 8'd0;
            1:       return 8'd255;
            2:       return 8'd128;
            3:       return 8'd127;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic run_op(input logic m, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] exp_res, input logic ec, input logic eo,
                          input logic ez, input int poke);
        calc_t c;
        bit    found;
        int    k;
        c = model_calc(m, x, y);
        check("model_res",  64'(c.res), 64'(exp_res));
        check("model_cout", 64'(c.co),  64'(ec));
        check("model_ovf",  64'(c.ov),  64'(eo));
        check("model_zero", 64'(c.z),   64'(ez));
        start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
        tick();
        start8 = 1'b0; a8 = pick(); b8 = pick(); mode8 = ~m;
        check("busy_after_start", 64'(busy8), 64'(1'b1));
        found = 1'b0;
        k = 0;
        while (!found && k < W8 + 3) begin
            k++;
            if (k == poke) begin
                start8 = 1'b1; a8 = pick(); b8 = pick(); mode8 = ~m;
            end
            tick();
            start8 = 1'b0;
            if (done8 === 1'b1) found = 1'b1;
        end
        check("latency",    64'(k),       64'(W8));
        check("dir_result", 64'(result8), 64'(exp_res));
        check("dir_cout",   64'(cout8),   64'(ec));
        check("dir_ovf",    64'(ovf8),    64'(eo));
        check("dir_zero",   64'(zero8),   64'(ez));
    endtask

    task automatic run_small(input int sel, input logic m, input logic [15:0] x,
                             input logic [15:0] y, input logic [15:0] exp_res,
                             input logic ec, input logic eo, input logic ez, input int lat);
        bit         found;
        int         k;
        logic       d;
        logic [15:0] r;
        if (sel == 0) begin
            start16 = 1'b1; mode16 = m; a16 = x; b16 = y;
        end else begin
            start2 = 1'b1; mode2 = m; a2 = x[1:0]; b2 = y[1:0];
        end
        tick();
        start16 = 1'b0; start2 = 1'b0;
        check("small_busy", 64'((sel == 0) ? busy16 : busy2), 64'(1'b1));
        found = 1'b0;
        k = 0;
        while (!found && k < lat + 3) begin
            k++;
            tick();
            d = (sel == 0) ? done16 : done2;
            if (d === 1'b1) found = 1'b1;
        end
        r = (sel == 0) ? result16 : {14'd0, result2};
        check("small_latency", 64'(k), 64'(lat));
        check("small_result",  64'(r), 64'(exp_res));
        check("small_cout", 64'((sel == 0) ? cout16 : cout2), 64'(ec));
        check("small_ovf",  64'((sel == 0) ? ovf16  : ovf2),  64'(eo));
        check("small_zero", 64'((sel == 0) ? zero16 : zero2), 64'(ez));
    endtask

    initial begin
        reset = 1'b0;
        start8 = 1'b0; mode8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        start16 = 1'b0; mode16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
        start2 = 1'b0; mode2 = 1'b0; a2 = 2'd0; b2 = 2'd0;
        #2 reset = 1'b1;
        #1;
        check("rst_busy",   64'(busy8),   64'(1'b0));
        check("rst_done",   64'(done8),   64'(1'b0));
        check("rst_result", 64'(result8), 64'(8'd0));
        check("rst_flags",  64'({cout8, ovf8, zero8}), 64'(3'b000));
        check("rst_w16",    64'(result16), 64'(16'd0));
        tick();
        tick();
        reset = 1'b0;
        tick();

        run_op(1'b1, 8'd23,  8'd2,   8'd21,  1'b0, 1'b0, 1'b0, 0);
        run_op(1'b1, 8'd8,   8'd23,  8'd241, 1'b1, 1'b0, 1'b0, 0);
        run_op(1'b0, 8'd100, 8'd50,  8'd150, 1'b0, 1'b1, 1'b0, 0);
        run_op(1'b0, 8'd200, 8'd123, 8'd67,  1'b1, 1'b0, 1'b0, 0);
        run_op(1'b1, 8'd74,  8'd74,  8'd0,   1'b0, 1'b0, 1'b1, 0);
        repeat (3) tick();

        // Start during RUN is ignored; start in the done cycle chains back-to-back.
        run_op(1'b0, 8'd5,   8'd9,   8'd14,  1'b0, 1'b0, 1'b0, 3);
        run_op(1'b1, 8'd110, 8'd42,  8'd68,  1'b0, 1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of an operation.
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'd77; b8 = 8'd11;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        check("async_busy",   64'(busy8),   64'(1'b0));
        check("async_done",   64'(done8),   64'(1'b0));
        check("async_result", 64'(result8), 64'(8'd0));
        check("async_flags",  64'({cout8, ovf8, zero8}), 64'(3'b000));
        tick();
        reset = 1'b0;
        for (int i = 0; i < W8 + 4; i++) begin
            tick();
            check("no_done_after_reset", 64'(done8), 64'(1'b0));
        end
        run_op(1'b0, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 500; i++) begin
            start8 = ($urandom_range(0, 2) == 0);
            mode8  = 1'($urandom_range(0, 1));
            a8     = pick();
            b8     = pick();
            tick();
            if ($urandom_range(0, 149) == 0) begin
                #3 reset = 1'b1;
                #1 compare_all();
                tick();
                reset = 1'b0;
            end
        end
        start8 = 1'b0;
        repeat (W8 + 2) tick();

        run_small(0, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16);
        run_small(0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 16);
        run_small(0, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 16);
        run_small(1, 1'b0, 16'd1,    16'd1,    16'd2,    1'b0, 1'b1, 1'b0, 2);
        run_small(1, 1'b1, 16'd0,    16'd1,    16'd3,    1'b1, 1'b0, 1'b0, 2);
        run_small(1, 1'b1, 16'd2,    16'd2,    16'd0,    1'b0, 1'b0, 1'b1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
